// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: arbitration signals shared between the bus masters'
// side (requests, muxed transfer status) and the arbiter (grants, owner).
`timescale 1ns/1ps
interface ahb_bus_arbiter_if #(
   parameter int NUM_MASTERS = 4
);
   localparam int MW = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] HBUSREQ;
   logic [NUM_MASTERS-1:0] HLOCK;
   logic [1:0]             HTRANS;
   logic [2:0]             HBURST;
   logic                   HREADY;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [MW-1:0]          HMASTER;
   logic                   HMASTLOCK;

   // Requesting side: masters plus the muxed transfer status
   modport master (
      output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      input  HGRANT, HMASTER, HMASTLOCK
   );

   // Arbiter side
   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      output HGRANT, HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: AHB shared-bus arbiter. Round-robin grant over HBUSREQ,
// never breaking a fixed-length burst or a locked sequence; HMASTER and
// HMASTLOCK follow the grant on the next HREADY edge.
// Optional build macro AHB_ARB_FIXED_PRIO_EN: lowest requesting index wins
// instead of round-robin.
`timescale 1ns/1ps
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input logic               HCLK,
   input logic               HRESETn,
   ahb_bus_arbiter_if.slave  bus
);
   localparam int MW = $clog2(NUM_MASTERS);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   localparam logic [1:0] ST_LOCK  = 2'd3;

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

   // Beats remaining after the first one of a burst of the given type
   function automatic logic [3:0] burst_load(input logic [2:0] hb);
      logic [3:0] n;
      case (hb)
         3'd2, 3'd3: n = 4'd3;
         3'd4, 3'd5: n = 4'd7;
         3'd6, 3'd7: n = 4'd15;
         default:    n = 4'd0;
      endcase
      return n;
   endfunction

   function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
      logic [NUM_MASTERS-1:0] oh;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         oh[i] = (idx == MW'(i));
      end
      return oh;
   endfunction

`ifdef AHB_ARB_FIXED_PRIO_EN
   // Lowest requesting index wins
   function automatic logic [MW-1:0] fixed_pick(input logic [NUM_MASTERS-1:0] req);
      logic [MW-1:0] win;
      logic          found;
      win   = DEF_IDX;
      found = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found && req[i]) begin
            win   = MW'(i);
            found = 1'b1;
         end
      end
      return win;
   endfunction
`else
   // First requester above the current owner, wrapping; owner comes last
   function automatic logic [MW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                             input logic [MW-1:0]          base);
      logic [MW-1:0] win;
      logic          found;
      win   = DEF_IDX;
      found = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found && req[i] && (i > int'(base))) begin
            win   = MW'(i);
            found = 1'b1;
         end
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found && req[i] && (i <= int'(base))) begin
            win   = MW'(i);
            found = 1'b1;
         end
      end
      return win;
   endfunction
`endif

   logic [1:0]             state_q, state_d;
   logic [3:0]             beats_q, beats_d;
   logic [MW-1:0]          gidx_q, gidx_d;       // index of the granted master
   logic [NUM_MASTERS-1:0] grant_q;
   logic [MW-1:0]          hmaster_q;
   logic                   hmastlock_q;

   logic                   acc_nseq, acc_seq;
   logic [3:0]             load;
   logic                   burst_start;
   logic                   arb_ok;
   logic [MW-1:0]          winner;

   // Burst counter, arbitration enable and next owner/state
   always_comb begin
      acc_nseq    = bus.HREADY && (bus.HTRANS == TR_NONSEQ);
      acc_seq     = bus.HREADY && (bus.HTRANS == TR_SEQ);
      load        = burst_load(bus.HBURST);
      burst_start = acc_nseq && (load != 4'd0);

      beats_d = beats_q;
      if (bus.HREADY) begin
         if (acc_nseq) begin
            beats_d = load;
         end else if (acc_seq) begin
            if (beats_q != 4'd0) beats_d = beats_q - 4'd1;
         end else if (bus.HTRANS == TR_IDLE) begin
            beats_d = 4'd0;
         end
      end

`ifdef AHB_ARB_FIXED_PRIO_EN
      winner = fixed_pick(bus.HBUSREQ);
`else
      winner = rr_pick(bus.HBUSREQ, gidx_q);
`endif

      // A burst starting on this edge keeps its owner. Inside a burst the
      // bus is released when the accepted SEQ leaves exactly one beat, so
      // the new grant is visible during the last address phase.
      case (state_q)
         ST_BURST: arb_ok = acc_seq && (beats_d == 4'd1);
         ST_LOCK:  arb_ok = !bus.HLOCK[gidx_q];
         default:  arb_ok = !burst_start;
      endcase
      arb_ok = arb_ok && bus.HREADY;

      state_d = state_q;
      gidx_d  = gidx_q;
      if (arb_ok) begin
         if (bus.HBUSREQ == '0) begin
            state_d = ST_IDLE;
            gidx_d  = DEF_IDX;
         end else begin
            gidx_d = winner;
            if (bus.HLOCK[winner])  state_d = ST_LOCK;
            else if (burst_start)   state_d = ST_BURST;
            else                    state_d = ST_GRANT;
         end
      end else if (bus.HREADY) begin
         case (state_q)
            ST_IDLE, ST_GRANT: if (burst_start)      state_d = ST_BURST;
            ST_BURST:          if (beats_d == 4'd0)  state_d = ST_GRANT;
            default:           state_d = state_q;
         endcase
      end
   end

   // Arbitration state and registered grant
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         beats_q <= 4'd0;
         gidx_q  <= DEF_IDX;
         grant_q <= DEF_GRANT;
      end else begin
         state_q <= state_d;
         beats_q <= beats_d;
         gidx_q  <= gidx_d;
         grant_q <= onehot(gidx_d);
      end
   end

   // Address-phase handover: owner index and lock follow the grant on HREADY
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hmaster_q   <= DEF_IDX;
         hmastlock_q <= 1'b0;
      end else if (bus.HREADY) begin
         hmaster_q   <= gidx_q;
         hmastlock_q <= bus.HLOCK[gidx_q];
      end
   end

   assign bus.HGRANT    = grant_q;
   assign bus.HMASTER   = hmaster_q;
   assign bus.HMASTLOCK = hmastlock_q;
endmodule
